// File: rtl/psram_req_arb_if.sv
// Requester-side and PSRAM-controller-side bundle for psram_req_arb.
// The slave modport is the arbiter's view. The master modport is the view of the surrounding requesters and controller.
interface psram_req_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ*STRB_W-1:0] req_wstrb_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]         req_rdata_o;

  logic                      mem_valid_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic [DATA_W-1:0]         mem_wdata_o;
  logic [STRB_W-1:0]         mem_wstrb_o;
  logic                      mem_ready_i;
  logic [DATA_W-1:0]         mem_rdata_i;

  logic                      busy_o;
  logic [2:0]                gnt_idx_o;
  logic                      err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i, mem_ready_i, mem_rdata_i,
    output req_ready_o, req_rdata_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output busy_o, gnt_idx_o, err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_wstrb_i, mem_ready_i, mem_rdata_i,
    input  req_ready_o, req_rdata_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  busy_o, gnt_idx_o, err_o
  );
endinterface

// File: rtl/psram_req_arb.sv
// Round-robin PSRAM port arbiter. The memory request appears 1 cycle after grant and is held until mem_ready_i; the ready pulse plus one DONE cycle follow.
// Optional watchdog under PSRAM_REQ_ARB_TIMEOUT_EN completes a stuck access with 0xDEADBEEF and sets sticky err_o.
module psram_req_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  psram_req_arb_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("psram_req_arb: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q;
  logic                mem_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]   mem_wstrb_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [DATA_W-1:0]   req_rdata_q;
  logic [2:0]          gnt_q;
`ifdef PSRAM_REQ_ARB_TIMEOUT_EN
  logic [15:0]         cnt_q;
  logic                err_q;
`endif

  logic       any_vld;
  logic [2:0] gnt_d;
  logic [7:0] vld8;
  logic [3:0] sum;
  logic [2:0] idx;

  // Scan nearest-last so the first set bit after gnt_q wins.
  always_comb begin
    any_vld = 1'b0;
    gnt_d   = gnt_q;
    vld8    = 8'(bus.req_valid_i);
    sum     = '0;
    idx     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      sum = {1'b0, gnt_q} + 4'(i);
      idx = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
      if (vld8[idx]) begin
        any_vld = 1'b1;
        gnt_d   = idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      req_ready_q <= '0;
      req_rdata_q <= '0;
      gnt_q       <= 3'(NUM_REQ - 1);
`ifdef PSRAM_REQ_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_vld) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= bus.req_addr_i[int'(gnt_d)*ADDR_W +: ADDR_W];
            mem_wdata_q <= bus.req_wdata_i[int'(gnt_d)*DATA_W +: DATA_W];
            mem_wstrb_q <= bus.req_wstrb_i[int'(gnt_d)*STRB_W +: STRB_W];
            gnt_q       <= gnt_d;
            state_q     <= BUSY;
`ifdef PSRAM_REQ_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        BUSY: begin
          // A real completion takes precedence over a coincident timeout.
          if (bus.mem_ready_i) begin
            mem_valid_q <= 1'b0;
            req_ready_q <= NUM_REQ'(1) << gnt_q;
            req_rdata_q <= bus.mem_rdata_i;
            state_q     <= DONE;
          end
`ifdef PSRAM_REQ_ARB_TIMEOUT_EN
          else if (cnt_q + 16'd1 == 16'(TIMEOUT_CYC)) begin
            mem_valid_q <= 1'b0;
            req_ready_q <= NUM_REQ'(1) << gnt_q;
            req_rdata_q <= DATA_W'(32'hDEAD_BEEF);
            err_q       <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_valid_o = mem_valid_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_wstrb_o = mem_wstrb_q;
  assign bus.req_ready_o = req_ready_q;
  assign bus.req_rdata_o = req_rdata_q;
  assign bus.busy_o      = (state_q == BUSY);
  assign bus.gnt_idx_o   = gnt_q;
`ifdef PSRAM_REQ_ARB_TIMEOUT_EN
  assign bus.err_o       = err_q;
`else
  assign bus.err_o       = 1'b0;
`endif
endmodule

// File: tb/tb_psram_req_arb.sv
// Directed bench for psram_req_arb: reset, single read, priority after service, reset mid-BUSY, round-robin, write latch, optional timeout.
module tb_psram_req_arb;
  localparam int NR = 4;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psram_req_arb_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  psram_req_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW-1:0] addr_tab [NR];
  logic [DW-1:0] wdat_tab [NR];
  logic [SW-1:0] strb_tab [NR];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_fields();
    for (int k = 0; k < NR; k++) begin
      bus.req_addr_i[k*AW +: AW]  = addr_tab[k];
      bus.req_wdata_i[k*DW +: DW] = wdat_tab[k];
      bus.req_wstrb_i[k*SW +: SW] = strb_tab[k];
    end
  endtask

  // Called on a negedge; waits for the grant, then the controller answers after lat cycles of mem_valid_o.
  task automatic serve(input int lat, input logic [DW-1:0] rd, input logic [1:0] g, input string tag);
    int n = 0;
    while (bus.mem_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".mvld"}, 64'(bus.mem_valid_o), 64'd1);
    chk({tag, ".gnt"},  64'(bus.gnt_idx_o), 64'(g));
    chk({tag, ".addr"}, 64'(bus.mem_addr_o), 64'(addr_tab[g]));
    repeat (lat - 1) @(negedge clk);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = rd;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    chk({tag, ".rdy"},   64'(bus.req_ready_o), 64'(4'b0001 << g));
    chk({tag, ".rdata"}, 64'(bus.req_rdata_o), 64'(rd));
    chk({tag, ".mvld0"}, 64'(bus.mem_valid_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] seen;
    int n;

    rst = 1'b1;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_wstrb_i = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    addr_tab = '{24'h000100, 24'h001110, 24'h002220, 24'h003330};
    wdat_tab = '{32'h0000_0000, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    strb_tab = '{4'h0, 4'h0, 4'h0, 4'h0};
    load_fields();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst.mvld",  64'(bus.mem_valid_o), 64'd0);
    chk("rst.addr",  64'(bus.mem_addr_o), 64'd0);
    chk("rst.wdata", 64'(bus.mem_wdata_o), 64'd0);
    chk("rst.wstrb", 64'(bus.mem_wstrb_o), 64'd0);
    chk("rst.rdy",   64'(bus.req_ready_o), 64'd0);
    chk("rst.rdata", 64'(bus.req_rdata_o), 64'd0);
    chk("rst.busy",  64'(bus.busy_o), 64'd0);
    chk("rst.gnt",   64'(bus.gnt_idx_o), 64'd3);
    chk("rst.err",   64'(bus.err_o), 64'd0);
    rst = 1'b0;

    // Single read from req0, controller answers after 5 cycles
    @(negedge clk);
    bus.req_valid_i = 4'b0001;
    @(negedge clk);
    chk("rd1.mvld_lat", 64'(bus.mem_valid_o), 64'd1);
    chk("rd1.busy",     64'(bus.busy_o), 64'd1);
    chk("rd1.wstrb",    64'(bus.mem_wstrb_o), 64'd0);
    serve(5, 32'h1234_5678, 2'd0, "rd1");
    chk("rd1.busy_lo", 64'(bus.busy_o), 64'd0);
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("rd1.rdy_1cyc", 64'(bus.req_ready_o), 64'd0);

    // Priority after service: req1 served, then req1+req3 -> req3 first
    bus.req_valid_i = 4'b0010;
    serve(3, 32'h0000_0011, 2'd1, "pr1");
    bus.req_valid_i = 4'b1010;
    serve(3, 32'h0000_0033, 2'd3, "pr3");
    bus.req_valid_i = 4'b0010;
    serve(3, 32'h0000_0111, 2'd1, "pr1b");
    bus.req_valid_i = '0;
    @(negedge clk);

    // Reset two cycles after grant
    bus.req_valid_i = 4'b0001;
    @(negedge clk);
    chk("rs.mvld", 64'(bus.mem_valid_o), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rs.mvld0", 64'(bus.mem_valid_o), 64'd0);
    chk("rs.rdy0",  64'(bus.req_ready_o), 64'd0);
    chk("rs.gnt",   64'(bus.gnt_idx_o), 64'd3);
    chk("rs.busy0", 64'(bus.busy_o), 64'd0);
    bus.req_valid_i = '0;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready_i = 1'b1;
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | bus.req_ready_o | {3'b0, bus.mem_valid_o};
    end
    bus.mem_ready_i = 1'b0;
    chk("rs.no_pulse", 64'(seen), 64'd0);

    // Round-robin with all four requesting continuously
    bus.req_valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve(3, 32'hA000_0000 + 32'(k), 2'(k % 4), $sformatf("rr%0d", k));
      if (k == 4) bus.req_valid_i = '0;
      @(negedge clk);
      chk($sformatf("rr%0d.gap", k), 64'(bus.mem_valid_o), 64'd0);
      chk($sformatf("rr%0d.rdy0", k), 64'(bus.req_ready_o), 64'd0);
      if (k < 4) begin
        @(negedge clk);
        chk($sformatf("rr%0d.regrant", k), 64'(bus.mem_valid_o), 64'd1);
      end
    end

    // Write latch: req2 changes fields and drops valid after grant
    wdat_tab[2] = 32'hCAFE_F00D;
    strb_tab[2] = 4'hF;
    load_fields();
    bus.req_valid_i = 4'b0100;
    @(negedge clk);
    chk("wl.wdata", 64'(bus.mem_wdata_o), 64'hCAFE_F00D);
    chk("wl.wstrb", 64'(bus.mem_wstrb_o), 64'hF);
    wdat_tab[2] = 32'h1111_1111;
    strb_tab[2] = 4'h0;
    load_fields();
    bus.req_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wl.hold_wdata", 64'(bus.mem_wdata_o), 64'hCAFE_F00D);
    end
    chk("wl.hold_wstrb", 64'(bus.mem_wstrb_o), 64'hF);
    serve(1, 32'h0000_0000, 2'd2, "wl");
    @(negedge clk);

    // Controller that never answers
    bus.req_valid_i = 4'b1000;
`ifdef PSRAM_REQ_ARB_TIMEOUT_EN
    n = 0;
    while (bus.mem_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("to.mvld", 64'(bus.mem_valid_o), 64'd1);
    n = 0;
    while (bus.req_ready_o == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to.cycles", 64'(n), 64'd16);
    chk("to.rdy",    64'(bus.req_ready_o), 64'b1000);
    chk("to.rdata",  64'(bus.req_rdata_o), 64'hDEAD_BEEF);
    chk("to.err",    64'(bus.err_o), 64'd1);
    chk("to.mvld0",  64'(bus.mem_valid_o), 64'd0);
    bus.req_valid_i = '0;
    repeat (3) @(negedge clk);
    chk("to.err_sticky", 64'(bus.err_o), 64'd1);
`else
    serve(2, 32'h0000_3333, 2'd3, "nto");
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("nto.err", 64'(bus.err_o), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
